// File: rtl/dct2_16_row_ctrl_if.sv
// Row stream bundle for dct2_16_row_ctrl: residual rows in, registered
// transform result rows out, each side with its own valid/ready handshake.
interface dct2_16_row_ctrl_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [9:0]  in_x [0:15];
    logic               out_valid;
    logic               out_ready;
    logic signed [10:0] out_ye [0:7];
    logic signed [19:0] out_yo [0:7];
    logic [3:0]         out_row;
    logic               out_last;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_ye, out_yo, out_row, out_last
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_ye, out_yo, out_row, out_last
    );
endinterface

// File: rtl/dct2_16_row_ctrl.sv
// Row sequencer for a 16-point DCT-II row pass: feeds an external combinational
// datapath and holds one result row. Optional stall counter: DCT2_16_ROW_CTRL_STALLCNT_EN.
module dct2_16_row_ctrl #(
    parameter int unsigned NROWS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    dct2_16_row_ctrl_if.slave  bus,
    output logic signed [9:0]  dp_x [0:15],
    input  logic signed [10:0] dp_ye [0:7],
    input  logic signed [19:0] dp_yo [0:7],
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);

    // state | meaning
    // IDLE  | no block in progress, waiting for row 0
    // ROWS  | rows 0..NROWS-1 of a block being accepted
    // DRAIN | last row captured, waiting for it to be taken downstream
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROWS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] ROW_LAST = 4'(NROWS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rcnt;
    logic       hs_in;
    logic       hs_out;
    logic       row_is_last;

    assign dp_x         = bus.in_x;
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !abort;
    assign hs_in        = bus.in_valid && bus.in_ready;
    assign hs_out       = bus.out_valid && bus.out_ready;
    assign row_is_last  = (rcnt == ROW_LAST);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs_in) begin
                    state_nxt = ROWS;
                end
            end
            ROWS: begin
                if (hs_in && row_is_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Row 0 of the next block may be accepted in the same cycle the last row leaves.
                if (hs_out && bus.out_last) begin
                    state_nxt = hs_in ? ROWS : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_last  <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                bus.out_ye[i] <= '0;
                bus.out_yo[i] <= '0;
            end
        end else begin
            done <= hs_out && bus.out_last && !abort;
            if (abort) begin
                rcnt          <= '0;
                bus.out_valid <= 1'b0;
            end else if (hs_in) begin
                rcnt          <= row_is_last ? 4'd0 : rcnt + 4'd1;
                bus.out_valid <= 1'b1;
                bus.out_row   <= rcnt;
                bus.out_last  <= row_is_last;
                for (int i = 0; i < 8; i++) begin
                    bus.out_ye[i] <= dp_ye[i];
                    bus.out_yo[i] <= dp_yo[i];
                end
            end else if (hs_out) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef DCT2_16_ROW_CTRL_STALLCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dct2_16_row_ctrl.sv
// Scoreboard bench for dct2_16_row_ctrl: a 16-row instance for directed block
// scenarios and a 4-row instance under random backpressure.
module tb_dct2_16_row_ctrl;

    typedef struct packed {
        logic [7:0][10:0] ye;
        logic [7:0][19:0] yo;
        logic [3:0]       row;
        logic             last;
    } exp_t;

    localparam logic [3:0] LAST16 = 4'd15;
    localparam logic [3:0] LAST4  = 4'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic abort;
    logic abort4;

    dct2_16_row_ctrl_if bus ();
    dct2_16_row_ctrl_if bus4 ();

    logic signed [9:0]  dp_x  [0:15];
    logic signed [10:0] dp_ye [0:7];
    logic signed [19:0] dp_yo [0:7];
    logic signed [9:0]  dp4_x  [0:15];
    logic signed [10:0] dp4_ye [0:7];
    logic signed [19:0] dp4_yo [0:7];
    logic               busy, done, busy4, done4;
    logic [15:0]        stall_cnt, stall4;

    dct2_16_row_ctrl #(.NROWS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus),
        .dp_x(dp_x), .dp_ye(dp_ye), .dp_yo(dp_yo),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    dct2_16_row_ctrl #(.NROWS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .abort(abort4), .bus(bus4),
        .dp_x(dp4_x), .dp_ye(dp4_ye), .dp_yo(dp4_yo),
        .busy(busy4), .done(done4), .stall_cnt(stall4)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    // Stand-in datapath: butterfly sums and weighted differences.
    function automatic logic [7:0][10:0] f_ye(input logic [15:0][9:0] x);
        int a, b;
        for (int k = 0; k < 8; k++) begin
            a = $signed(x[k]);
            b = $signed(x[15-k]);
            f_ye[k] = 11'(a + b);
        end
    endfunction

    function automatic logic [7:0][19:0] f_yo(input logic [15:0][9:0] x);
        int a, b;
        for (int k = 0; k < 8; k++) begin
            a = $signed(x[k]);
            b = $signed(x[15-k]);
            f_yo[k] = 20'((a - b) * (k * 8 + 13));
        end
    endfunction

    function automatic exp_t mk_exp(input logic [15:0][9:0] x, input logic [3:0] row, input logic last);
        mk_exp.ye   = f_ye(x);
        mk_exp.yo   = f_yo(x);
        mk_exp.row  = row;
        mk_exp.last = last;
    endfunction

    function automatic logic [15:0][9:0] pat(input int r);
        for (int i = 0; i < 16; i++) pat[i] = 10'((r * 37 + i * 53 + 7) % 1024);
    endfunction

    logic [15:0][9:0] xp, xp4;
    logic [7:0][10:0] yep, yep4;
    logic [7:0][19:0] yop, yop4;

    always_comb begin
        xp = '0;
        for (int i = 0; i < 16; i++) xp[i] = dp_x[i];
        yep = f_ye(xp);
        yop = f_yo(xp);
        for (int k = 0; k < 8; k++) begin
            dp_ye[k] = yep[k];
            dp_yo[k] = yop[k];
        end
    end

    always_comb begin
        xp4 = '0;
        for (int i = 0; i < 16; i++) xp4[i] = dp4_x[i];
        yep4 = f_ye(xp4);
        yop4 = f_yo(xp4);
        for (int k = 0; k < 8; k++) begin
            dp4_ye[k] = yep4[k];
            dp4_yo[k] = yop4[k];
        end
    end

    exp_t       q [$];
    exp_t       q4 [$];
    logic [3:0] exp_row  = '0;
    logic [3:0] exp_row4 = '0;
    bit         exp_done = 1'b0;
    int         done_cnt = 0;
    bit         chk_lat  = 1'b0;

    // Monitor for the 16-row instance: held row must match the front of the queue.
    exp_t             m_e;
    logic [7:0][10:0] m_ye;
    logic [7:0][19:0] m_yo;
    always @(negedge clk) begin
        if (exp_done || done === 1'b1) chk("done_pulse", done, exp_done);
        if (done === 1'b1) done_cnt++;
        exp_done = 1'b0;
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1'b1, 1'b0);
            end else begin
                m_e = q[0];
                for (int k = 0; k < 8; k++) begin
                    m_ye[k] = bus.out_ye[k];
                    m_yo[k] = bus.out_yo[k];
                end
                chk("out_ye", m_ye, m_e.ye);
                chk("out_yo", m_yo, m_e.yo);
                chk("out_row", bus.out_row, m_e.row);
                chk("out_last", bus.out_last, m_e.last);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    exp_done = m_e.last && rst_n && !abort;
                end
            end
        end
    end

    exp_t             m4_e;
    logic [7:0][10:0] m4_ye;
    logic [7:0][19:0] m4_yo;
    always @(negedge clk) begin
        if (bus4.out_valid === 1'b1) begin
            if (q4.size() == 0) begin
                chk("n4_unexpected_out_valid", 1'b1, 1'b0);
            end else begin
                m4_e = q4[0];
                for (int k = 0; k < 8; k++) begin
                    m4_ye[k] = bus4.out_ye[k];
                    m4_yo[k] = bus4.out_yo[k];
                end
                chk("n4_out_ye", m4_ye, m4_e.ye);
                chk("n4_out_yo", m4_yo, m4_e.yo);
                chk("n4_out_row", bus4.out_row, m4_e.row);
                chk("n4_out_last", bus4.out_last, m4_e.last);
                if (bus4.out_ready) void'(q4.pop_front());
            end
        end
    end

    task automatic drive_x(input logic [15:0][9:0] x);
        for (int i = 0; i < 16; i++) bus.in_x[i] = x[i];
    endtask

    task automatic neg();
        @(negedge clk);
        if (chk_lat) begin
            chk("capture_latency", bus.out_valid, 1'b1);
            chk_lat = 1'b0;
        end
    endtask

    task automatic send_row(input logic [15:0][9:0] x, input bit must_accept);
        bit acc;
        acc = 1'b0;
        drive_x(x);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            neg();
            if (must_accept && c == 0) chk("in_ready_high", bus.in_ready, 1'b1);
            if (bus.in_ready === 1'b1) begin
                q.push_back(mk_exp(x, exp_row, exp_row == LAST16));
                exp_row = (exp_row == LAST16) ? 4'd0 : exp_row + 4'd1;
                chk_lat = 1'b1;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            neg();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        logic [7:0][10:0] aye;
        logic [7:0][19:0] ayo;
        for (int k = 0; k < 8; k++) begin
            aye[k] = bus.out_ye[k];
            ayo[k] = bus.out_yo[k];
        end
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_out_row"}, bus.out_row, 4'd0);
        chk({tag, "_out_last"}, bus.out_last, 1'b0);
        chk({tag, "_out_ye"}, aye, '0);
        chk({tag, "_out_yo"}, ayo, '0);
        chk({tag, "_stall_cnt"}, stall_cnt, 16'd0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][9:0] x;
        logic [15:0][9:0] x4;
        bit               all_busy;
        int               exp_stall;

        rst_n          = 1'b0;
        abort          = 1'b0;
        abort4         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        drive_x('0);
        for (int i = 0; i < 16; i++) bus4.in_x[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single block, no backpressure, impulse on sample 0.
        done_cnt = 0;
        x = '0;
        x[0] = 10'd100;
        for (int r = 0; r < 16; r++) send_row(x, 1'b1);
        idle(3);
        chk("blk1_done_count", done_cnt, 1);
        chk("blk1_busy_after", busy, 1'b0);

        // Downstream stalls for 5 cycles while row 3 is held.
        for (int r = 0; r < 4; r++) send_row(pat(r), 1'b1);
        bus.out_ready = 1'b0;
        drive_x(pat(4));
        bus.in_valid = 1'b1;
        repeat (5) begin
            neg();
            chk("stall_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send_row(pat(4), 1'b0);
        for (int r = 5; r < 16; r++) send_row(pat(r), 1'b1);
        idle(3);
`ifdef DCT2_16_ROW_CTRL_STALLCNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", stall_cnt, 16'(exp_stall));

        // Abort presented together with row 7.
        for (int r = 0; r < 7; r++) send_row(pat(r + 20), 1'b1);
        idle(1);
        abort = 1'b1;
        drive_x(pat(27));
        bus.in_valid = 1'b1;
        neg();
        chk("abort_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        exp_row = 4'd0;
        neg();
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        for (int r = 0; r < 16; r++) send_row(pat(r + 40), 1'b1);
        idle(3);

        // Two blocks back to back: DRAIN hands straight over to ROWS.
        done_cnt = 0;
        all_busy = 1'b1;
        for (int r = 0; r < 32; r++) begin
            send_row(pat(r + 60), 1'b1);
            if (busy !== 1'b1) all_busy = 1'b0;
        end
        chk("b2b_busy_held", all_busy, 1'b1);
        idle(3);
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_busy_after", busy, 1'b0);

        // Reset mid-block while row 8 is held and row 9 is offered.
        for (int r = 0; r < 9; r++) send_row(pat(r + 100), 1'b1);
        rst_n = 1'b0;
        drive_x(pat(109));
        bus.in_valid = 1'b1;
        neg();
        @(posedge clk);
        #1;
        neg();
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        exp_row = 4'd0;
        chk("midrst_queue_empty", 32'(q.size()), 32'd0);
        send_row(pat(200), 1'b1);
        send_row(pat(201), 1'b1);
        idle(2);

        // 4-row instance under random valid/ready.
        for (int c = 0; c < 300; c++) begin
            bus4.in_valid  = ($urandom_range(0, 3) != 0);
            bus4.out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 16; i++) x4[i] = 10'($urandom_range(0, 1023));
            for (int i = 0; i < 16; i++) bus4.in_x[i] = x4[i];
            @(negedge clk);
            if (bus4.in_valid && bus4.in_ready === 1'b1) begin
                q4.push_back(mk_exp(x4, exp_row4, exp_row4 == LAST4));
                exp_row4 = (exp_row4 == LAST4) ? 4'd0 : exp_row4 + 4'd1;
            end
            @(posedge clk);
            #1;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("n4_queue_drained", 32'(q4.size()), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dct2_16_row_ctrl.md
DCT2_16_ROW_CTRL -- requirements
Module: dct2_16_row_ctrl

Interface
REQ-001 SHALL have parameter: NROWS, default 16, rows per block (legal 2..16).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: abort  in  1  synchronous block abort.
REQ-005 SHALL have port: in_valid  in  1  input row valid.
REQ-006 SHALL have port: in_ready  out  1  input row accepted when in_valid&&in_ready.
REQ-007 SHALL have port: in_x[0:15]  in  10 signed each  residual row samples.
REQ-008 SHALL have port: dp_x[0:15]  out  10 signed each  samples to 16-point row datapath.
REQ-009 SHALL have port: dp_ye[0:7]  in  11 signed each  datapath even terms.
REQ-010 SHALL have port: dp_yo[0:7]  in  20 signed each  datapath odd terms.
REQ-011 SHALL have port: out_valid  out  1  result row valid.
REQ-012 SHALL have port: out_ready  in  1  downstream accepts when out_valid&&out_ready.
REQ-013 SHALL have port: out_ye[0:7]  out  11 signed each; out_yo[0:7]  out  20 signed each  registered result.
REQ-014 SHALL have port: out_row  out  4  row index of held result (0..NROWS-1).
REQ-015 SHALL have port: out_last  out  1  held result is row NROWS-1.
REQ-016 SHALL have port: busy  out  1  block in progress; done  out  1  one-cycle pulse.
REQ-017 SHALL have port: stall_cnt  out  16  output stall counter.

Function
REQ-018 SHALL drive dp_x = in_x combinationally at all times; datapath is external and combinational.
REQ-019 SHALL assert in_ready = !out_valid || out_ready, forced 0 when abort=1.
REQ-020 SHALL, on input handshake, register dp_ye/dp_yo sign-preserving without modification into out_ye/out_yo, set out_valid=1 next cycle (latency exactly 1 cycle).
REQ-021 SHALL clear out_valid on output handshake without a same-cycle input handshake; simultaneous in/out handshakes replace the held row with no bubble.
REQ-022 SHALL hold out_ye, out_yo, out_row, out_last stable while out_valid && !out_ready.
REQ-023 SHALL keep row counter rcnt (4 bits): increments on each input handshake, wraps NROWS-1 -> 0; out_row = rcnt value at capture.
REQ-024 SHALL implement FSM states IDLE, ROWS, DRAIN.
REQ-025 IDLE -> ROWS on input handshake of row 0; ROWS -> DRAIN on input handshake of row NROWS-1; DRAIN -> IDLE on output handshake of last row; DRAIN -> ROWS if that same cycle accepts row 0 of the next block.
REQ-026 SHALL assert busy in ROWS and DRAIN; done pulses one cycle in the cycle after output handshake with out_last=1.
REQ-027 SHALL treat abort (wins over any same-cycle handshake): next cycle FSM=IDLE, rcnt=0, out_valid=0, done=0; stall_cnt unaffected.
REQ-028 SHALL treat in_valid with in_ready=0 as a no-op; inputs need not be held by the controller.

Reset
REQ-029 SHALL, with rst_n=0 at a rising edge, set FSM=IDLE, rcnt=0, out_valid=0, out_ye/out_yo/out_row=0, out_last=0, busy=0, done=0, stall_cnt=0.
REQ-030 SHALL have reset mid-block discard all held data and override abort and handshakes.

Configuration
REQ-031 SHALL support macro DCT2_16_ROW_CTRL_STALLCNT_EN: when defined, stall_cnt increments each cycle with out_valid=1 && out_ready=0, saturating at 16'hFFFF, cleared only by reset.
REQ-032 SHALL, with DCT2_16_ROW_CTRL_STALLCNT_EN undefined, tie stall_cnt to 0 with no counter logic.

Verification
REQ-033 SHALL cover: 16 back-to-back rows, out_ready=1, in_x[0]=100, rest 0 -> out_valid from cycle 1, out_row 0..15, out_last on row 15, done one cycle after, in_ready never 0.
REQ-034 SHALL cover: out_ready=0 for 5 cycles after row 3 captured -> out_* stable, in_ready=0 throughout, stall_cnt=5 (0 if macro undefined).
REQ-035 SHALL cover: abort asserted together with in_valid at row 7 -> no capture, next cycle busy=0, out_valid=0, following accepted row reported out_row=0.
REQ-036 SHALL cover: two consecutive blocks with out_ready=1 -> DRAIN->ROWS direct transition, busy stays 1, exactly two done pulses.
REQ-037 SHALL cover: rst_n=0 at row 9 with out_valid=1 -> all outputs at reset values next cycle.
REQ-038 SHALL cover: NROWS=4, random out_ready -> out_row sequence 0,1,2,3,0,... with out_last on row 3 only; captured values equal datapath outputs for the accepted row.
